// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, 16x oversampled, 1 start / DBIT data (LSB first) / 1 stop bit.
// Outputs update one clk after the completing tick; no backpressure, the consumer must take dout on rx_done_tick.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int DB_TICK = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int TMAX = (DB_TICK > SB_TICK) ? DB_TICK : SB_TICK;
  localparam int SW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(DB_TICK / 2 - 1);
  localparam logic [SW-1:0] S_DBIT = SW'(DB_TICK - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic [DBIT-1:0] r_dout, w_dout_nxt;
  logic            r_done, w_done_nxt;
  logic            r_ferr, w_ferr_nxt;
  logic            r_sync1, r_rx_s;
  logic [DBIT:0]   w_b_cat;

  assign w_b_cat      = {r_rx_s, r_b};
  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (r_s == S_MID) begin
            // A line that is high again at mid start bit was only a glitch.
            if (!r_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (r_s == S_DBIT) begin
            w_s_nxt = '0;
            w_b_nxt = w_b_cat[DBIT:1];
            if (r_n == N_LAST) w_state_nxt = STOP;
            else               w_n_nxt     = r_n + 1'b1;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (r_s == S_STOP) begin
            w_dout_nxt  = r_b;
            w_done_nxt  = 1'b1;
            w_ferr_nxt  = ~r_rx_s;
            w_state_nxt = r_rx_s ? IDLE : WAIT_HIGH;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line recovers so a break is reported only once.
        if (r_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
